bpu_bht: RTL and testbench



---
 rtl/bpu_bht.sv | 191 +++++++++++++++++++
 tb/tb_bpu_bht.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_bht.sv
// -----------------------------------------------------------------------------
// bpu_bht -- IF-stage branch history table (direct-mapped, 2-bit counters)
//
// Purpose:
//   Predicts, in the same cycle as the fetch, whether the instruction at
//   if_pc_i is a taken branch and where it goes. A direct-mapped table of
//   2^IDX_W entries holds {valid, tag, target, 2-bit saturating counter}.
//   Branches resolved in EX train the table on the rising clock edge.
//   A lookup never sees an update made in the same cycle; there is no bypass.
//
// Optional feature (macro BPU_STATS_EN):
//   Adds ex_prd_taken_i, stat_br_cnt_o and stat_miss_cnt_o. These are
//   free-running 32-bit counts of applied updates and of mispredicted updates.
//
// Ports:
//   clk              in   1       clock
//   rstn             in   1       asynchronous active-low reset
//   if_pc_i          in   ADDR_W  PC being fetched
//   if_valid_i       in   1       fetch slot holds a real instruction
//   prd_jump_en_o    out  1       predict taken
//   prd_jump_addr_o  out  ADDR_W  predicted target, 0 when not predicting taken
//   ex_br_valid_i    in   1       control transfer resolved in EX
//   ex_hold_i        in   1       EX stalled; the update waits
//   ex_pc_i          in   ADDR_W  PC of the resolved branch
//   ex_taken_i       in   1       actual outcome, 1 = taken
//   ex_target_i      in   ADDR_W  actual target
//   ex_prd_taken_i   in   1       (BPU_STATS_EN) prediction carried for this branch
//   stat_br_cnt_o    out  32      (BPU_STATS_EN) applied update count
//   stat_miss_cnt_o  out  32      (BPU_STATS_EN) misprediction count
// -----------------------------------------------------------------------------
module bpu_bht #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] if_pc_i,
    input  logic              if_valid_i,
    output logic              prd_jump_en_o,
    output logic [ADDR_W-1:0] prd_jump_addr_o,
    input  logic              ex_br_valid_i,
    input  logic              ex_hold_i,
    input  logic [ADDR_W-1:0] ex_pc_i,
    input  logic              ex_taken_i,
`ifdef BPU_STATS_EN
    input  logic              ex_prd_taken_i,
    output logic [31:0]       stat_br_cnt_o,
    output logic [31:0]       stat_miss_cnt_o,
`endif
    input  logic [ADDR_W-1:0] ex_target_i
);

    localparam int DEPTH = 1 << IDX_W;

    // Counter encoding: bit 1 is the taken prediction.
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Saturating increment towards strongly taken.
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        if (c == CTR_ST) begin
            return CTR_ST;
        end else begin
            return c + 2'b01;
        end
    endfunction

    // Saturating decrement towards strongly not-taken.
    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        if (c == CTR_SNT) begin
            return CTR_SNT;
        end else begin
            return c - 2'b01;
        end
    endfunction

    // Table storage
    logic [DEPTH-1:0]  valid_r;
    logic [TAG_W-1:0]  tag_r    [DEPTH];
    logic [ADDR_W-1:0] target_r [DEPTH];
    logic [1:0]        ctr_r    [DEPTH];

    // Field extraction (pc[1:0] is always ignored)
    logic [IDX_W-1:0] if_idx_s;
    logic [TAG_W-1:0] if_tag_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic [TAG_W-1:0] ex_tag_s;
    logic             if_hit_s;
    logic             ex_hit_s;
    logic             upd_s;

    assign if_idx_s = if_pc_i[IDX_W+1:2];
    assign if_tag_s = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx_s = ex_pc_i[IDX_W+1:2];
    assign ex_tag_s = ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // A stalled EX holds the branch; the update lands once, when the stall lifts.
    assign upd_s = ex_br_valid_i & ~ex_hold_i;

    // PC bits outside the index/tag fields do not take part in prediction.
    logic unused_pc_bits_s;
    assign unused_pc_bits_s = ^{if_pc_i[1:0], if_pc_i[ADDR_W-1:IDX_W+TAG_W+2],
                                ex_pc_i[1:0], ex_pc_i[ADDR_W-1:IDX_W+TAG_W+2]};

    // Combinational lookup of the fetch PC and the EX PC against the table.
    always_comb begin
        if_hit_s        = 1'b0;
        ex_hit_s        = 1'b0;
        prd_jump_en_o   = 1'b0;
        prd_jump_addr_o = '0;
        if (if_valid_i && valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s)) begin
            if_hit_s = 1'b1;
        end else begin
            if_hit_s = 1'b0;
        end
        if (valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s)) begin
            ex_hit_s = 1'b1;
        end else begin
            ex_hit_s = 1'b0;
        end
        if (if_hit_s && ctr_r[if_idx_s][1]) begin
            prd_jump_en_o   = 1'b1;
            prd_jump_addr_o = target_r[if_idx_s];
        end else begin
            prd_jump_en_o   = 1'b0;
            prd_jump_addr_o = '0;
        end
    end

    // Table training from resolved EX branches; async reset clears the table.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_r[i]    <= '0;
                target_r[i] <= '0;
                ctr_r[i]    <= CTR_WNT;
            end
        end else if (upd_s) begin
            if (ex_hit_s) begin
                if (ex_taken_i) begin
                    ctr_r[ex_idx_s]    <= ctr_inc(ctr_r[ex_idx_s]);
                    target_r[ex_idx_s] <= ex_target_i;
                end else begin
                    ctr_r[ex_idx_s]    <= ctr_dec(ctr_r[ex_idx_s]);
                end
            end else if (ex_taken_i) begin
                // Miss on a taken branch: claim the slot, evicting any alias.
                valid_r[ex_idx_s]  <= 1'b1;
                tag_r[ex_idx_s]    <= ex_tag_s;
                target_r[ex_idx_s] <= ex_target_i;
                ctr_r[ex_idx_s]    <= CTR_WT;
            end else begin
                // Not-taken miss leaves the table alone.
                valid_r <= valid_r;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] br_cnt_r;
    logic [31:0] miss_cnt_r;

    // Branch and misprediction statistics, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_cnt_r   <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else if (upd_s) begin
            br_cnt_r <= br_cnt_r + 32'd1;
            if (ex_taken_i != ex_prd_taken_i) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
        end else begin
            br_cnt_r   <= br_cnt_r;
            miss_cnt_r <= miss_cnt_r;
        end
    end

    assign stat_br_cnt_o   = br_cnt_r;
    assign stat_miss_cnt_o = miss_cnt_r;
`endif

endmodule

// File: tb/tb_bpu_bht.sv
// -----------------------------------------------------------------------------
// tb_bpu_bht -- self-checking bench for bpu_bht.
// Directed steps for the listed scenarios, then a randomized phase, all checked
// against a table model built from integer counters and arrays.
// -----------------------------------------------------------------------------
module tb_bpu_bht;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] if_pc_i = 32'd0;
    logic        if_valid_i = 1'b0;
    logic        prd_jump_en_o;
    logic [31:0] prd_jump_addr_o;
    logic        ex_br_valid_i = 1'b0;
    logic        ex_hold_i = 1'b0;
    logic [31:0] ex_pc_i = 32'd0;
    logic        ex_taken_i = 1'b0;
    logic [31:0] ex_target_i = 32'd0;
`ifdef BPU_STATS_EN
    logic        ex_prd_taken_i = 1'b0;
    logic [31:0] stat_br_cnt_o;
    logic [31:0] stat_miss_cnt_o;
    int unsigned m_br_cnt;
    int unsigned m_miss_cnt;
`endif

    bpu_bht dut (
        .clk             (clk),
        .rstn            (rstn),
        .if_pc_i         (if_pc_i),
        .if_valid_i      (if_valid_i),
        .prd_jump_en_o   (prd_jump_en_o),
        .prd_jump_addr_o (prd_jump_addr_o),
        .ex_br_valid_i   (ex_br_valid_i),
        .ex_hold_i       (ex_hold_i),
        .ex_pc_i         (ex_pc_i),
        .ex_taken_i      (ex_taken_i),
`ifdef BPU_STATS_EN
        .ex_prd_taken_i  (ex_prd_taken_i),
        .stat_br_cnt_o   (stat_br_cnt_o),
        .stat_miss_cnt_o (stat_miss_cnt_o),
`endif
        .ex_target_i     (ex_target_i)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: counter strength as integer 0..3 (>=2 means taken).
    bit          m_valid [64];
    int unsigned m_tag   [64];
    int unsigned m_tgt   [64];
    int          m_str   [64];

    function automatic int unsigned idx_of(input int unsigned pc);
        return (pc / 4) % 64;
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return (pc / 256) % 256;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_str[i]   = 1;
        end
`ifdef BPU_STATS_EN
        m_br_cnt   = 0;
        m_miss_cnt = 0;
`endif
    endtask

    task automatic model_predict(input int unsigned pc, input bit v,
                                 output bit en, output int unsigned addr);
        int unsigned i;
        i = idx_of(pc);
        en = v && m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_str[i] >= 2);
        addr = en ? m_tgt[i] : 0;
    endtask

    task automatic model_update(input int unsigned pc, input bit tk, input int unsigned tgt);
        int unsigned i;
        i = idx_of(pc);
        if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
            if (tk) begin
                m_str[i] = (m_str[i] == 3) ? 3 : m_str[i] + 1;
                m_tgt[i] = tgt;
            end else begin
                m_str[i] = (m_str[i] == 0) ? 0 : m_str[i] - 1;
            end
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(pc);
            m_tgt[i]   = tgt;
            m_str[i]   = 2;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    endtask

    // One cycle: drive at negedge, check the zero-latency lookup, then let the
    // model take the update that the DUT applies at the coming posedge.
    task automatic step(input string name, input int unsigned pc, input bit v,
                        input bit br, input bit hold, input int unsigned epc,
                        input bit tk, input int unsigned tgt, input bit prd);
        bit          e_en;
        int unsigned e_addr;
        @(negedge clk);
        if_pc_i       = pc;
        if_valid_i    = v;
        ex_br_valid_i = br;
        ex_hold_i     = hold;
        ex_pc_i       = epc;
        ex_taken_i    = tk;
        ex_target_i   = tgt;
`ifdef BPU_STATS_EN
        ex_prd_taken_i = prd;
`endif
        #1;
        model_predict(pc, v, e_en, e_addr);
        chk({name, "_en"}, {31'd0, prd_jump_en_o}, {31'd0, e_en});
        chk({name, "_addr"}, prd_jump_addr_o, e_addr);
`ifdef BPU_STATS_EN
        chk({name, "_brcnt"}, stat_br_cnt_o, m_br_cnt);
        chk({name, "_misscnt"}, stat_miss_cnt_o, m_miss_cnt);
        if (br && !hold) begin
            m_br_cnt++;
            if (tk != prd) m_miss_cnt++;
        end
`else
        if (prd) e_en = e_en;
`endif
        if (br && !hold) model_update(epc, tk, tgt);
    endtask

    initial begin
        model_clear();
        rstn = 1'b0;
        if_pc_i = 32'h100;
        if_valid_i = 1'b1;
        #1;
        chk("in_reset_en", {31'd0, prd_jump_en_o}, 32'd0);
        chk("in_reset_addr", prd_jump_addr_o, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Cold lookup misses
        step("cold", 32'h100, 1, 0, 0, 0, 0, 0, 0);
        chk("cold_en_k", {31'd0, prd_jump_en_o}, 32'd0);
        chk("cold_addr_k", prd_jump_addr_o, 32'd0);
        // Same-cycle lookup sees old contents
        step("alloc", 32'h100, 1, 1, 0, 32'h100, 1, 32'h200, 0);
        chk("same_cycle_k", {31'd0, prd_jump_en_o}, 32'd0);
        // Counter walk 10,11,10,01,00,00 then taken -> 01
        step("w10", 32'h100, 1, 1, 0, 32'h100, 1, 32'h200, 1);
        chk("w10_en_k", {31'd0, prd_jump_en_o}, 32'd1);
        chk("w10_addr_k", prd_jump_addr_o, 32'h200);
        step("w11", 32'h100, 1, 1, 0, 32'h100, 0, 32'h0, 1);
        chk("w11_en_k", {31'd0, prd_jump_en_o}, 32'd1);
        step("w10b", 32'h100, 1, 1, 0, 32'h100, 0, 32'h0, 1);
        chk("w10b_en_k", {31'd0, prd_jump_en_o}, 32'd1);
        step("w01", 32'h100, 1, 1, 0, 32'h100, 0, 32'h0, 0);
        chk("w01_en_k", {31'd0, prd_jump_en_o}, 32'd0);
        step("w00", 32'h100, 1, 1, 0, 32'h100, 0, 32'h0, 0);
        chk("w00_en_k", {31'd0, prd_jump_en_o}, 32'd0);
        step("w00s", 32'h100, 1, 1, 0, 32'h100, 1, 32'h200, 0);
        chk("w00s_en_k", {31'd0, prd_jump_en_o}, 32'd0);
        step("w01b", 32'h100, 1, 0, 0, 0, 0, 0, 0);
        chk("sat_low_k", {31'd0, prd_jump_en_o}, 32'd0);

        // Held branch steps the counter exactly once (01 -> 10)
        for (int k = 0; k < 3; k++) step("hold", 32'h100, 1, 1, 1, 32'h100, 1, 32'h200, 0);
        step("release", 32'h100, 1, 1, 0, 32'h100, 1, 32'h200, 0);
        step("after_rel", 32'h100, 1, 1, 0, 32'h100, 0, 32'h0, 1);
        chk("after_rel_k", {31'd0, prd_jump_en_o}, 32'd1);
        step("after_nt", 32'h100, 1, 0, 0, 0, 0, 0, 0);
        chk("one_step_k", {31'd0, prd_jump_en_o}, 32'd0);

        // Alias: same idx, different tag evicts
        step("re_alloc", 32'h0, 0, 1, 0, 32'h100, 1, 32'h200, 0);
        step("alias_upd", 32'h0, 0, 1, 0, 32'h4100, 1, 32'h300, 0);
        step("alias_old", 32'h100, 1, 0, 0, 0, 0, 0, 0);
        chk("alias_old_k", {31'd0, prd_jump_en_o}, 32'd0);
        step("alias_new", 32'h4100, 1, 0, 0, 0, 0, 0, 0);
        chk("alias_new_en_k", {31'd0, prd_jump_en_o}, 32'd1);
        chk("alias_new_addr_k", prd_jump_addr_o, 32'h300);
        step("not_valid", 32'h4100, 0, 0, 0, 0, 0, 0, 0);
        chk("not_valid_k", {31'd0, prd_jump_en_o}, 32'd0);

        // Asynchronous reset mid-operation, with an update in flight
        @(negedge clk);
        if_pc_i = 32'h4100;
        if_valid_i = 1'b1;
        ex_br_valid_i = 1'b1;
        ex_hold_i = 1'b0;
        ex_pc_i = 32'h4100;
        ex_taken_i = 1'b1;
        ex_target_i = 32'h500;
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_en", {31'd0, prd_jump_en_o}, 32'd0);
        chk("async_rst_addr", prd_jump_addr_o, 32'd0);
        model_clear();
        @(negedge clk);
        ex_br_valid_i = 1'b0;
        rstn = 1'b1;
        step("post_rst", 32'h4100, 1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_k", {31'd0, prd_jump_en_o}, 32'd0);

        // Randomized phase over a small PC pool to force hits and aliases
        for (int n = 0; n < 400; n++) begin
            int unsigned lpc;
            int unsigned upc;
            lpc = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            upc = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            step("rand", lpc, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, upc, $urandom_range(0, 2) != 0,
                 $urandom, $urandom_range(0, 1) == 1);
        end
        step("final", 32'h0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
